bip_control_unit: RTL and testbench

- Control stage feeding the BIP accumulator datapath: holds the program counter and fetches 16-bit instructions (5-bit opcode, 11-bit operand) from program memory.
- Decodes each instruction into the datapath selects and the data-memory strobes, and runs a small IDLE/RUN/HALT sequencer.
- Program memory is read combinationally: i_instruction reflects o_pc in the same cycle.
- One instruction completes per valid cycle.

---
 rtl/bip_control_unit_if.sv | 40 ++++
 rtl/bip_control_unit.sv | 108 ++++++++++
 tb/tb_bip_control_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/bip_control_unit_if.sv
// Control-unit bus: program-memory fetch, sequencer controls and the decoded datapath controls.
// No latency of its own; it only groups wires.
// No backpressure; i_valid is a global enable, and a low value stalls the unit.
interface bip_control_unit_if #(
  parameter int NB_DATA            = 16,
  parameter int LOG2_N_INSMEM_ADDR = 11,
  parameter int LOG2_N_DATA_ADDR   = 10,
  parameter int NB_SEL_A           = 2,
  parameter int NB_DATA_S_EXT      = 10,
  parameter int NB_COUNT           = 32
) ();
  logic                          i_valid;
  logic                          i_start;
  logic [NB_DATA-1:0]            i_instruction;
  logic [LOG2_N_INSMEM_ADDR-1:0] o_pc;
  logic [NB_SEL_A-1:0]           o_sel_a;
  logic                          o_sel_b;
  logic                          o_op_code;
  logic                          o_wr_acc;
  logic                          o_wr_ram;
  logic                          o_rd_ram;
  logic [LOG2_N_DATA_ADDR-1:0]   o_data_addr;
  logic [NB_DATA_S_EXT-1:0]      o_data_instruction;
  logic                          o_halted;
  logic [NB_COUNT-1:0]           o_instr_count;

  // The control unit uses the master modport.
  modport master (
    input  i_valid, i_start, i_instruction,
    output o_pc, o_sel_a, o_sel_b, o_op_code, o_wr_acc, o_wr_ram, o_rd_ram,
           o_data_addr, o_data_instruction, o_halted, o_instr_count
  );

  // The program memory, the datapath and the driver use the slave modport.
  modport slave (
    output i_valid, i_start, i_instruction,
    input  o_pc, o_sel_a, o_sel_b, o_op_code, o_wr_acc, o_wr_ram, o_rd_ram,
           o_data_addr, o_data_instruction, o_halted, o_instr_count
  );
endinterface

// File: rtl/bip_control_unit.sv
// Purpose: BIP control stage. It holds the PC, decodes the instruction, and runs the IDLE/RUN/HALT sequencer.
// Latency: decode is combinational from i_instruction, and PC, count and state advance on the same edge.
//          No bubbles occur between instructions.
// Backpressure: i_valid low freezes PC, count and state, and forces every strobe to 0.
// Ports: i_clock, i_reset (async, active-high), bus (bip_control_unit_if.master): fetch,
//        sequencer controls, datapath selects, memory strobes, halted flag, instruction count.
module bip_control_unit #(
  parameter int NB_DATA            = 16,
  parameter int NB_OPCODE          = 5,
  parameter int NB_OPERAND         = 11,
  parameter int N_INSMEM_ADDR      = 2048,
  parameter int LOG2_N_INSMEM_ADDR = 11,
  parameter int LOG2_N_DATA_ADDR   = 10,
  parameter int NB_SEL_A           = 2,
  parameter int NB_DATA_S_EXT      = 10,
  parameter int NB_COUNT           = 32
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  bip_control_unit_if.master       bus
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HALT = 2'b10;

  localparam logic [NB_OPCODE-1:0] OP_HLT  = 5'b00000;
  localparam logic [NB_OPCODE-1:0] OP_STO  = 5'b00001;
  localparam logic [NB_OPCODE-1:0] OP_LD   = 5'b00010;
  localparam logic [NB_OPCODE-1:0] OP_LDI  = 5'b00011;
  localparam logic [NB_OPCODE-1:0] OP_ADD  = 5'b00100;
  localparam logic [NB_OPCODE-1:0] OP_ADDI = 5'b00101;
  localparam logic [NB_OPCODE-1:0] OP_SUB  = 5'b00110;
  localparam logic [NB_OPCODE-1:0] OP_SUBI = 5'b00111;

  localparam logic [LOG2_N_INSMEM_ADDR-1:0] PC_LAST = LOG2_N_INSMEM_ADDR'(N_INSMEM_ADDR - 1);

  logic [1:0]                    state;
  logic [LOG2_N_INSMEM_ADDR-1:0] pc;
  logic [NB_COUNT-1:0]           count;
  logic [NB_OPCODE-1:0]          opcode;
  logic                          go;
  logic                          exec;

  assign opcode = bus.i_instruction[NB_DATA-1 -: NB_OPCODE];
  assign go     = bus.i_start & bus.i_valid;
  // Strobes also see i_reset directly, so a reset asserted mid-cycle kills the pending write at once.
  assign exec   = (state == ST_RUN) & bus.i_valid & ~i_reset;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state <= ST_IDLE;
      pc    <= '0;
      count <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (go) begin
            state <= ST_RUN;
            pc    <= '0;
            count <= '0;
          end
        end
        ST_RUN: begin
          if (bus.i_valid) begin
            count <= (count == '1) ? count : count + 1'b1;
            if (opcode == OP_HLT) begin
              state <= ST_HALT;          // The PC stays on the HLT address.
            end else begin
              pc <= (pc == PC_LAST) ? '0 : pc + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.o_sel_a   = '0;
    bus.o_sel_b   = 1'b0;
    bus.o_op_code = 1'b0;
    bus.o_wr_acc  = 1'b0;
    bus.o_wr_ram  = 1'b0;
    bus.o_rd_ram  = 1'b0;
    if (exec) begin
      case (opcode)
        OP_STO:  bus.o_wr_ram = 1'b1;
        OP_LD:   begin bus.o_sel_a = 2'b00; bus.o_wr_acc = 1'b1; bus.o_rd_ram = 1'b1; end
        OP_LDI:  begin bus.o_sel_a = 2'b01; bus.o_wr_acc = 1'b1; end
        OP_ADD:  begin bus.o_sel_a = 2'b10; bus.o_op_code = 1'b1; bus.o_wr_acc = 1'b1; bus.o_rd_ram = 1'b1; end
        OP_ADDI: begin bus.o_sel_a = 2'b10; bus.o_sel_b = 1'b1; bus.o_op_code = 1'b1; bus.o_wr_acc = 1'b1; end
        OP_SUB:  begin bus.o_sel_a = 2'b10; bus.o_wr_acc = 1'b1; bus.o_rd_ram = 1'b1; end
        OP_SUBI: begin bus.o_sel_a = 2'b10; bus.o_sel_b = 1'b1; bus.o_wr_acc = 1'b1; end
        default: ;                        // HLT and 01000-11111 (NOP) raise no strobes.
      endcase
    end
  end

  // The operand fields follow i_instruction in every state.
  // They are forced to zero only while reset is held, so every output reads 0 during reset.
  assign bus.o_data_addr        = i_reset ? '0 : bus.i_instruction[LOG2_N_DATA_ADDR-1:0];
  assign bus.o_data_instruction = i_reset ? '0 : bus.i_instruction[NB_DATA_S_EXT-1:0];
  assign bus.o_pc               = pc;
  assign bus.o_halted           = (state == ST_HALT);
  assign bus.o_instr_count      = count;

endmodule

// File: tb/tb_bip_control_unit.sv
module tb_bip_control_unit;

  logic i_clock = 1'b0;
  logic i_reset = 1'b1;
  always #5 i_clock = ~i_clock;

  bip_control_unit_if bus ();
  bip_control_unit dut (.i_clock(i_clock), .i_reset(i_reset), .bus(bus));

  typedef struct packed {
    logic [10:0] pc;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        op;
    logic        wr_acc;
    logic        wr_ram;
    logic        rd_ram;
    logic [9:0]  addr;
    logic [9:0]  di;
    logic        halted;
    logic [31:0] count;
  } obs_t;

  typedef struct {
    logic        valid;
    logic        start;
    logic [15:0] instr;
    obs_t        exp;
  } vec_t;

  vec_t        vecs[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] acc = '0;
  logic [15:0] mem [0:1023];

  function automatic obs_t mk(input logic [15:0] instr, input logic [10:0] pc, input logic [1:0] sel_a,
                              input logic sel_b, input logic op, input logic wa, input logic wr,
                              input logic rd, input logic halted, input logic [31:0] count);
    obs_t o;
    o = '{pc: pc, sel_a: sel_a, sel_b: sel_b, op: op, wr_acc: wa, wr_ram: wr, rd_ram: rd,
          addr: instr[9:0], di: instr[9:0], halted: halted, count: count};
    return o;
  endfunction

  task automatic add(input logic v, input logic s, input logic [15:0] instr, input logic [10:0] pc,
                     input logic [1:0] sel_a, input logic sel_b, input logic op, input logic wa,
                     input logic wr, input logic rd, input logic halted, input logic [31:0] count);
    vec_t t;
    t.valid = v;
    t.start = s;
    t.instr = instr;
    t.exp   = mk(instr, pc, sel_a, sel_b, op, wa, wr, rd, halted, count);
    vecs.push_back(t);
  endtask

  function automatic obs_t sample();
    obs_t o;
    o = {bus.o_pc, bus.o_sel_a, bus.o_sel_b, bus.o_op_code, bus.o_wr_acc, bus.o_wr_ram,
         bus.o_rd_ram, bus.o_data_addr, bus.o_data_instruction, bus.o_halted, bus.o_instr_count};
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t exp);
    obs_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (pc,sel_a,sel_b,op,wa,wr,rd,addr,di,halt,cnt)", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // A minimal accumulator datapath that consumes the strobes the way the real datapath does.
  task automatic datapath_step();
    logic [15:0] imm;
    logic [15:0] b;
    imm = {{6{bus.o_data_instruction[9]}}, bus.o_data_instruction};
    b   = bus.o_sel_b ? imm : mem[bus.o_data_addr];
    if (bus.o_wr_ram) mem[bus.o_data_addr] = acc;
    if (bus.o_wr_acc) begin
      case (bus.o_sel_a)
        2'b00:   acc = mem[bus.o_data_addr];
        2'b01:   acc = imm;
        default: acc = bus.o_op_code ? acc + b : acc - b;
      endcase
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [15:0] instr);
    @(negedge i_clock);
    bus.i_valid       = v;
    bus.i_start       = s;
    bus.i_instruction = instr;
    #1;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(vecs[i].valid, vecs[i].start, vecs[i].instr);
      check_obs($sformatf("vec%0d", i), vecs[i].exp);
      datapath_step();
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[7] = 16'd20;
    bus.i_valid = 1'b0;
    bus.i_start = 1'b0;
    bus.i_instruction = 16'h1805;

    //  v  s  instr     pc  sa    sb op wa wr rd hlt cnt
    add(1, 1, 16'h1805, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0); // 0 IDLE + start
    add(1, 0, 16'h1805, 0, 2'b01, 0, 0, 1, 0, 0, 0, 0); // 1 LDI 5
    add(1, 0, 16'h2803, 1, 2'b10, 1, 1, 1, 0, 0, 0, 1); // 2 ADDI 3
    add(1, 0, 16'h0802, 2, 2'b00, 0, 0, 0, 1, 0, 0, 2); // 3 STO 2
    add(1, 0, 16'h0000, 3, 2'b00, 0, 0, 0, 0, 0, 0, 3); // 4 HLT
    add(1, 0, 16'h0000, 3, 2'b00, 0, 0, 0, 0, 0, 1, 4); // 5 halted
    add(1, 0, 16'h0000, 3, 2'b00, 0, 0, 0, 0, 0, 1, 4); // 6 sticky
    add(1, 1, 16'h1BFF, 3, 2'b00, 0, 0, 0, 0, 0, 1, 4); // 7 restart request
    add(1, 0, 16'h1BFF, 0, 2'b01, 0, 0, 1, 0, 0, 0, 0); // 8 LDI 0x3FF
    add(1, 0, 16'h1007, 1, 2'b00, 0, 0, 1, 0, 1, 0, 1); // 9 LD 7
    add(0, 0, 16'h3007, 2, 2'b00, 0, 0, 0, 0, 0, 0, 2); // 10 stall
    add(0, 1, 16'h3007, 2, 2'b00, 0, 0, 0, 0, 0, 0, 2); // 11 stall
    add(0, 0, 16'h3007, 2, 2'b00, 0, 0, 0, 0, 0, 0, 2); // 12 stall
    add(1, 0, 16'h3007, 2, 2'b10, 0, 0, 1, 0, 1, 0, 2); // 13 SUB 7
    add(1, 1, 16'h4000, 3, 2'b00, 0, 0, 0, 0, 0, 0, 3); // 14 NOP, start ignored in RUN
    add(1, 0, 16'h0000, 4, 2'b00, 0, 0, 0, 0, 0, 0, 4); // 15 HLT
    add(0, 1, 16'h0000, 4, 2'b00, 0, 0, 0, 0, 0, 1, 5); // 16 start without valid
    add(1, 0, 16'h0000, 4, 2'b00, 0, 0, 0, 0, 0, 1, 5); // 17 still halted

    #1;
    check_obs("reset", obs_t'(0));
    @(negedge i_clock);
    i_reset = 1'b0;

    run_vecs(0, 6);
    check_val("acc_after_prog", 32'(acc), 32'd8);
    run_vecs(7, 8);
    check_val("acc_sext", 32'(acc), 32'hFFFF);
    run_vecs(9, 17);
    check_val("acc_ld_sub", 32'(acc), 32'd0);

    // Restart from HALT, then run NOPs up to the last PC and wrap around.
    drive(1, 1, 16'h4000);
    drive(1, 0, 16'h4000);
    check_obs("restart", mk(16'h4000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 2046; i++) drive(1, 0, 16'h4000);
    check_obs("pc_last", mk(16'h4000, 11'd2046, 0, 0, 0, 0, 0, 0, 0, 2046));
    drive(1, 0, 16'h4000);
    check_obs("pc_top", mk(16'h4000, 11'd2047, 0, 0, 0, 0, 0, 0, 0, 2047));
    drive(1, 0, 16'h4000);
    check_obs("pc_wrap", mk(16'h4000, 11'd0, 0, 0, 0, 0, 0, 0, 0, 2048));

    // Assert reset asynchronously during an ADDI, between clock edges.
    drive(1, 0, 16'h2BFF);
    check_obs("addi_pre_rst", mk(16'h2BFF, 11'd1, 2'b10, 1, 1, 1, 0, 0, 0, 2049));
    #2 i_reset = 1'b1;
    #1;
    check_obs("async_rst", obs_t'(0));
    @(negedge i_clock);
    i_reset = 1'b0;
    drive(1, 0, 16'h2803);
    drive(1, 0, 16'h2803);
    check_obs("idle_no_start", mk(16'h2803, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(1, 1, 16'h2803);
    drive(1, 0, 16'h2803);
    check_obs("resume", mk(16'h2803, 0, 2'b10, 1, 1, 1, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
